// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode-side hazard control bundle: ID/EX/MEM hazard inputs, branch/interrupt requests, and buffer control outputs.
// master = pipeline side that drives hazard info; slave = hazard controller.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
);
  logic [REG_ADDR_W-1:0] id_src_addr;
  logic [REG_ADDR_W-1:0] id_dst_addr;
  logic                  id_uses_src;
  logic                  id_uses_dst;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_dst_addr;
  logic                  mem_reg_write;
  logic [REG_ADDR_W-1:0] mem_dst_addr;
  logic                  branch_taken;
  logic                  int_req;

  logic                  pc_write;
  logic                  ifid_write;
  logic                  ifid_flush;
  logic                  idex_bubble;
  logic                  int_active;
  logic [1:0]            int_step;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output id_src_addr, id_dst_addr, id_uses_src, id_uses_dst,
           ex_reg_write, ex_mem_read, ex_dst_addr,
           mem_reg_write, mem_dst_addr, branch_taken, int_req,
    input  pc_write, ifid_write, ifid_flush, idex_bubble,
           int_active, int_step, stall_count
  );

  modport slave (
    input  id_src_addr, id_dst_addr, id_uses_src, id_uses_dst,
           ex_reg_write, ex_mem_read, ex_dst_addr,
           mem_reg_write, mem_dst_addr, branch_taken, int_req,
    output pc_write, ifid_write, ifid_flush, idex_bubble,
           int_active, int_step, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: load-use/RAW stall, branch flush, and interrupt entry sequencing for IF/ID and ID/EX (macro FORWARD_EN = forwarding present).
// Latency: buffer controls are combinational from state and inputs; stall_count is registered (one cycle behind).
// Backpressure: a hazard holds PC and IF/ID and bubbles ID/EX; a taken branch overrides a stall; interrupts wait until RUN.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = 4,
  parameter int INT_CYCLES = 3,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_RUN, S_STALL, S_INT} state_t;

  localparam logic [1:0] LAST_STEP = 2'(INT_CYCLES - 1);

  state_t           state;
  logic [1:0]       stall_cnt;
  logic [1:0]       step_q;
  logic             int_pending;
  logic [CNT_W-1:0] stall_count_q;

  logic ex_hit, mem_hit, haz, haz_long;
  logic haz_cycle, int_accept;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, int_active;
  logic [1:0] int_step;

  function automatic logic hit(input logic [REG_ADDR_W-1:0] a,
                               input logic [REG_ADDR_W-1:0] src,
                               input logic [REG_ADDR_W-1:0] dst,
                               input logic use_src, input logic use_dst);
    return (use_src && src == a) || (use_dst && dst == a);
  endfunction

  assign ex_hit  = hit(bus.ex_dst_addr, bus.id_src_addr, bus.id_dst_addr,
                       bus.id_uses_src, bus.id_uses_dst);
  assign mem_hit = hit(bus.mem_dst_addr, bus.id_src_addr, bus.id_dst_addr,
                       bus.id_uses_src, bus.id_uses_dst);

`ifdef FORWARD_EN
  // Forwarding covers everything except a load feeding the very next instruction.
  logic unused_fwd;
  assign unused_fwd = ^{mem_hit, bus.mem_reg_write};
  assign haz      = bus.ex_mem_read && bus.ex_reg_write && ex_hit;
  assign haz_long = 1'b0;
`else
  logic unused_fwd;
  assign unused_fwd = bus.ex_mem_read;
  assign haz      = (bus.ex_reg_write && ex_hit) || (bus.mem_reg_write && mem_hit);
  assign haz_long = bus.ex_reg_write && ex_hit;
`endif

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    int_active  = 1'b0;
    int_step    = 2'd0;
    haz_cycle   = 1'b0;
    int_accept  = 1'b0;
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      case (state)
        S_RUN: begin
          if (bus.branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (haz) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            haz_cycle   = 1'b1;
          end else if (int_pending || bus.int_req) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            int_accept  = 1'b1;
          end
        end
        S_STALL: begin
          if (bus.branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            haz_cycle   = 1'b1;
          end
        end
        S_INT: begin
          int_active = 1'b1;
          int_step   = step_q;
          ifid_flush = 1'b1;
          pc_write   = (step_q == LAST_STEP);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_RUN;
      stall_cnt     <= 2'd0;
      step_q        <= 2'd0;
      int_pending   <= 1'b0;
      stall_count_q <= '0;
    end else begin
      if (haz_cycle && stall_count_q != '1)
        stall_count_q <= stall_count_q + 1'b1;

      if (int_accept)
        int_pending <= 1'b0;
      else if (bus.int_req)
        int_pending <= 1'b1;

      case (state)
        S_RUN: begin
          if (!bus.branch_taken && haz) begin
            stall_cnt <= haz_long ? 2'd1 : 2'd0;
            if (haz_long)
              state <= S_STALL;
          end else if (int_accept) begin
            state  <= S_INT;
            step_q <= 2'd0;
          end
        end
        S_STALL: begin
          if (bus.branch_taken) begin
            state <= S_RUN;
          end else begin
            stall_cnt <= stall_cnt - 2'd1;
            if (stall_cnt <= 2'd1)
              state <= S_RUN;
          end
        end
        S_INT: begin
          if (step_q == LAST_STEP) begin
            state  <= S_RUN;
            step_q <= 2'd0;
          end else begin
            step_q <= step_q + 2'd1;
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

  assign bus.pc_write    = pc_write;
  assign bus.ifid_write  = ifid_write;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_bubble = idex_bubble;
  assign bus.int_active  = int_active;
  assign bus.int_step    = int_step;
  assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized scoreboard bench for pipeline_hazard_ctrl; a narrow stall counter is used so saturation is reached.
module tb_pipeline_hazard_ctrl;
  localparam int RW = 4;
  localparam int IC = 3;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_ADDR_W(RW), .CNT_W(CW)) bus ();

  pipeline_hazard_ctrl #(.REG_ADDR_W(RW), .INT_CYCLES(IC), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic          pc_write;
    logic          ifid_write;
    logic          ifid_flush;
    logic          idex_bubble;
    logic          int_active;
    logic [1:0]    int_step;
    logic [CW-1:0] stall_count;
  } exp_t;

  typedef struct {
    bit          rst;
    logic [RW-1:0] src, dst, exd, memd;
    bit          us, ud, exw, exr, memw, br, irq;
  } stim_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: mode flags and plain counters derived from the behavioural rules.
  bit m_in_int = 0;
  int m_step   = 0;
  int m_left   = 0;   // stall cycles still owed after the current one
  bit m_pend   = 0;
  int m_cnt    = 0;

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.src = '0; s.dst = '0; s.exd = '0; s.memd = '0;
    s.us = 0; s.ud = 0; s.exw = 0; s.exr = 0; s.memw = 0; s.br = 0; s.irq = 0;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.rst  = ($urandom_range(0, 399) == 0);
    s.src  = RW'($urandom_range(0, 3));
    s.dst  = RW'($urandom_range(0, 3));
    s.exd  = RW'($urandom_range(0, 3));
    s.memd = RW'($urandom_range(0, 3));
    s.us   = $urandom_range(0, 1) == 1;
    s.ud   = $urandom_range(0, 1) == 1;
    s.exw  = $urandom_range(0, 1) == 1;
    s.exr  = $urandom_range(0, 9) < 3;
    s.memw = $urandom_range(0, 1) == 1;
    s.br   = $urandom_range(0, 7) == 0;
    s.irq  = $urandom_range(0, 11) == 0;
    return s;
  endfunction

  task automatic set_stall(inout exp_t e);
    e.pc_write = 0; e.ifid_write = 0; e.ifid_flush = 0; e.idex_bubble = 1;
    if (m_cnt < (1 << CW) - 1) m_cnt++;
  endtask

  task automatic set_flush(inout exp_t e);
    e.pc_write = 1; e.ifid_write = 1; e.ifid_flush = 1; e.idex_bubble = 1;
  endtask

  task automatic apply(input stim_t s);
    exp_t e;
    bit   exhit, memhit;
    int   need;
    @(posedge clk);
    #1;
    rst                = s.rst;
    bus.id_src_addr    = s.src;
    bus.id_dst_addr    = s.dst;
    bus.id_uses_src    = s.us;
    bus.id_uses_dst    = s.ud;
    bus.ex_reg_write   = s.exw;
    bus.ex_mem_read    = s.exr;
    bus.ex_dst_addr    = s.exd;
    bus.mem_reg_write  = s.memw;
    bus.mem_dst_addr   = s.memd;
    bus.branch_taken   = s.br;
    bus.int_req        = s.irq;

    exhit  = (s.us && s.src == s.exd)  || (s.ud && s.dst == s.exd);
    memhit = (s.us && s.src == s.memd) || (s.ud && s.dst == s.memd);
`ifdef FORWARD_EN
    need = (s.exr && s.exw && exhit) ? 1 : 0;
`else
    need = (s.exw && exhit) ? 2 : ((s.memw && memhit) ? 1 : 0);
`endif

    e = '0;
    e.stall_count = CW'(m_cnt);
    if (s.rst) begin
      e.ifid_flush = 1; e.idex_bubble = 1;
      m_in_int = 0; m_step = 0; m_left = 0; m_pend = 0; m_cnt = 0;
    end else if (m_in_int) begin
      e.int_active = 1; e.int_step = 2'(m_step); e.ifid_flush = 1;
      e.ifid_write = 1; e.pc_write = (m_step == IC - 1);
      if (s.irq) m_pend = 1;
      m_step++;
      if (m_step == IC) begin m_in_int = 0; m_step = 0; end
    end else if (m_left > 0) begin
      if (s.br) begin set_flush(e); m_left = 0; end
      else begin set_stall(e); m_left--; end
      if (s.irq) m_pend = 1;
    end else begin
      if (s.br) begin
        set_flush(e);
        if (s.irq) m_pend = 1;
      end else if (need > 0) begin
        set_stall(e);
        m_left = need - 1;
        if (s.irq) m_pend = 1;
      end else if (m_pend || s.irq) begin
        e.ifid_flush = 1; e.idex_bubble = 1;
        m_in_int = 1; m_step = 0; m_pend = 0;
      end else begin
        e.pc_write = 1; e.ifid_write = 1;
      end
    end
    expq.push_back(e);
  endtask

  // Monitor: every cycle the DUT presents a full set of control outputs.
  initial begin
    exp_t e, got;
    forever begin
      @(negedge clk);
      cyc++;
      if (expq.size() > 0) begin
        e   = expq.pop_front();
        got = {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_bubble,
               bus.int_active, bus.int_step, bus.stall_count};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL ctrl_outputs cyc %0d got pcw=%b ifw=%b fl=%b bub=%b act=%b step=%0d cnt=%0d required pcw=%b ifw=%b fl=%b bub=%b act=%b step=%0d cnt=%0d",
                   cyc, got.pc_write, got.ifid_write, got.ifid_flush, got.idex_bubble,
                   got.int_active, got.int_step, got.stall_count,
                   e.pc_write, e.ifid_write, e.ifid_flush, e.idex_bubble,
                   e.int_active, e.int_step, e.stall_count);
        end
      end
    end
  end

  initial begin
    stim_t s;
    int    wait_cnt;
    bus.id_src_addr = '0; bus.id_dst_addr = '0; bus.id_uses_src = 0; bus.id_uses_dst = 0;
    bus.ex_reg_write = 0; bus.ex_mem_read = 0; bus.ex_dst_addr = '0;
    bus.mem_reg_write = 0; bus.mem_dst_addr = '0; bus.branch_taken = 0; bus.int_req = 0;

    // Reset for two cycles, then idle.
    s = idle(); s.rst = 1;
    apply(s);
    #1;
    checks++;
    if (bus.pc_write !== 1'b0 || bus.ifid_write !== 1'b0 || bus.ifid_flush !== 1'b1 ||
        bus.idex_bubble !== 1'b1 || bus.int_active !== 1'b0 || bus.int_step !== 2'd0) begin
      errors++;
      $display("FAIL reset_state got pcw=%b ifw=%b fl=%b bub=%b act=%b step=%0d required pcw=0 ifw=0 fl=1 bub=1 act=0 step=0",
               bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_bubble,
               bus.int_active, bus.int_step);
    end
    apply(s);
    repeat (3) apply(idle());

    // RAW on EX destination via dst field.
    s = idle(); s.exw = 1; s.exd = 5; s.dst = 5; s.ud = 1;
    apply(s);
    repeat (3) apply(idle());

    // Load-use through the src field.
    s = idle(); s.exr = 1; s.exw = 1; s.exd = 3; s.src = 3; s.us = 1;
    apply(s);
    repeat (3) apply(idle());

    // MEM-only match, register 0 included.
    s = idle(); s.memw = 1; s.memd = 0; s.src = 0; s.us = 1;
    apply(s);
    repeat (2) apply(idle());

    // Hazard then branch on the next cycle.
    s = idle(); s.exw = 1; s.exr = 1; s.exd = 7; s.src = 7; s.us = 1;
    apply(s);
    s = idle(); s.br = 1;
    apply(s);
    repeat (2) apply(idle());

    // Interrupt with a second pulse during step 1.
    s = idle(); s.irq = 1;
    apply(s);
    apply(idle());
    apply(s);
    repeat (8) apply(idle());

    // Branch inside INT is ignored.
    s = idle(); s.irq = 1;
    apply(s);
    s = idle(); s.br = 1;
    repeat (3) apply(s);
    repeat (2) apply(idle());

    // Reset at interrupt step 1.
    s = idle(); s.irq = 1;
    apply(s);
    apply(idle());
    s = idle(); s.rst = 1;
    apply(s);
    repeat (4) apply(idle());

    for (int i = 0; i < 3000; i++) apply(rnd());

    wait_cnt = 0;
    while (expq.size() > 0 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain_wait expired after %0d cycles with %0d expectations outstanding",
               wait_cnt, expq.size());
    end

    repeat (3) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Sequences the IF/ID and ID/EX pipeline buffers of the 5-stage RISC core.
- Detects RAW load-use hazards and holds PC and IF/ID while injecting bubbles into ID/EX.
- Flushes on taken branches.
- Runs the multi-cycle interrupt entry sequence.
- Sits beside the decode stage; its outputs drive the buffer write enables, flushes and the control unit's interrupt microsteps.

Parameters:
REG_ADDR_W, 4, register address width (matches 4-bit dest/src address fields)
INT_CYCLES, 3, length of interrupt entry sequence in cycles (>=2): push PC, push flags, load vector
CNT_W, 16, width of stall performance counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
id_src_addr  in  REG_ADDR_W  source register of instruction in ID
id_dst_addr  in  REG_ADDR_W  destination register read by instruction in ID
id_uses_src  in  1  ID instruction reads id_src_addr
id_uses_dst  in  1  ID instruction reads id_dst_addr
ex_reg_write  in  1  instruction in EX writes a register
ex_mem_read  in  1  instruction in EX is a load
ex_dst_addr  in  REG_ADDR_W  EX write address
mem_reg_write  in  1  instruction in MEM writes a register
mem_dst_addr  in  REG_ADDR_W  MEM write address
branch_taken  in  1  taken branch/jump resolved in EX
int_req  in  1  interrupt request, single-cycle pulse or level
pc_write  out  1  PC register load enable
ifid_write  out  1  IF/ID buffer load enable
ifid_flush  out  1  IF/ID loads NOP
idex_bubble  out  1  ID/EX loads all-zero control (bubble)
int_active  out  1  interrupt sequence in progress
int_step  out  2  current interrupt microstep, 0..INT_CYCLES-1
stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Outputs are combinational from state and inputs. While rst=1 they are forced: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, int_active=0, int_step=0.
- Registered state resets as follows: state=RUN, stall_cnt=0, int_pending=0, stall_count=0.
- The 'hit' terms below are defined as: hit(a) = (id_uses_src && id_src_addr==a) || (id_uses_dst && id_dst_addr==a). R0 is not special.
- Load-use hazard (lu): ex_mem_read && ex_reg_write && hit(ex_dst_addr).
- States: RUN, STALL, INT.
- RUN, cycle priority:
  1. branch_taken: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1. Any hazard this cycle is ignored, because the ID instruction is flushed.
  2. Hazard: pc_write=0, ifid_write=0, idex_bubble=1. Load stall_cnt with the remaining stall cycles minus 1; if that is nonzero, go to STALL.
  3. int_pending or int_req: go to INT, step 0. This cycle pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1.
  4. Otherwise: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
- STALL: same outputs as a hazard cycle. stall_cnt decrements; when it is 0, go to RUN. branch_taken in STALL wins: apply the flush outputs and go to RUN.
- int_pending: set when int_req=1 and the request is not accepted that cycle; cleared on entry to INT. Requests arriving during INT are held pending and serviced after return.
- INT: int_active=1, ifid_flush=1, idex_bubble=0. The control unit injects push/load ops keyed by int_step.
  - pc_write=0 except at step INT_CYCLES-1, where pc_write=1 (vector load) and the state returns to RUN.
  - ifid_write=1.
  - branch_taken is ignored in INT.
- int_step increments each INT cycle; it is 0 outside INT.
- stall_count increments every cycle in which idex_bubble=1 due to a hazard (not flush, not reset); it saturates at all-ones.
- rst asserted mid-STALL or mid-INT aborts immediately to RUN with no pending interrupt.

Optional Feature:
FORWARD_EN.
- Defined (forwarding unit present): only lu stalls, for 1 cycle total; STALL is never entered.
- Undefined (no forwarding):
  - A hazard is hit(ex_dst_addr)&&ex_reg_write, which requires 2 stall cycles, or else hit(mem_dst_addr)&&mem_reg_write, which requires 1.
  - The EX match takes precedence, so stall_cnt loads 1 and STALL runs 1 extra cycle.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0, no hazards -> during reset pc_write=0, ifid_flush=1, idex_bubble=1; after release pc_write=1, ifid_write=1, stall_count=0.
- Load-use (FORWARD_EN): ex_mem_read=1, ex_reg_write=1, ex_dst_addr=3, id_src_addr=3, id_uses_src=1 -> exactly 1 cycle pc_write=0, idex_bubble=1; stall_count=1.
- No-forward RAW (FORWARD_EN off): ex_reg_write=1, ex_dst_addr=5, id_dst_addr=5, id_uses_dst=1 -> 2 consecutive stall cycles, then RUN; stall_count=2.
- Branch during stall: enter STALL, assert branch_taken next cycle -> ifid_flush=1, idex_bubble=1, pc_write=1; RUN on the following cycle.
- Interrupt: pulse int_req in RUN, INT_CYCLES=3 -> int_active=1 for 3 cycles with int_step 0,1,2; pc_write=1 only at step 2; a second int_req pulse during step 1 re-enters INT after one RUN cycle.
- Reset mid-INT: rst=1 at step 1 -> next cycle state RUN, int_active=0, int_pending=0.
